// File: rtl/phase_probe_tx.sv
// phase_probe_tx: initiator side of the start/echo phase measurement link.
// Fires a one-cycle start pulse every PERIOD+1 clk_fast cycles, measures the
// ticks until the far-end stop echo, flags missing echoes and averages
// 2^AVG_LOG2 good samples into phase_avg.
// Ports:
//   clk_fast    counting clock
//   rstn        asynchronous active-low reset
//   enable      run probing (level)
//   stop        echo from far end, synchronous to clk_fast
//   clear_err   clears timeout_err
//   start       probe pulse, one cycle wide
//   busy        high while firing or waiting for the echo
//   phase_diff  last good single measurement
//   phase_avg   mean of the last 2^AVG_LOG2 good measurements
//   avg_valid   one-cycle pulse when phase_avg updates
//   timeout_err sticky missed-echo flag
module phase_probe_tx #(
   parameter int CNT_W    = 16,
   parameter int PERIOD   = 1000,
   parameter int TIMEOUT  = 255,
   parameter int AVG_LOG2 = 3
) (
   input  logic             clk_fast,
   input  logic             rstn,
   input  logic             enable,
   input  logic             stop,
   input  logic             clear_err,
   output logic             start,
   output logic             busy,
   output logic [CNT_W-1:0] phase_diff,
   output logic [CNT_W-1:0] phase_avg,
   output logic             avg_valid,
   output logic             timeout_err
);
   localparam int PW    = $clog2(PERIOD + 1);
   localparam int SUM_W = CNT_W + AVG_LOG2;
   typedef enum logic [1:0] {IDLE, FIRE, WAIT, GAP} state_t;
   state_t state, next;
   logic [CNT_W-1:0]  tick;
   logic [PW-1:0]     timer;
   logic [SUM_W-1:0]  sum, sum_n;
   logic [AVG_LOG2:0] cnt, cnt_n;
   logic              hit, tout;
   assign hit   = (state == WAIT) && stop;
   assign tout  = (state == WAIT) && !stop && (tick == CNT_W'(TIMEOUT));
   assign sum_n = sum + SUM_W'(tick);
   assign cnt_n = cnt + 1'b1;
   always_ff @(posedge clk_fast or negedge rstn)
      if (!rstn) state <= IDLE;
      else       state <= next;
   // Leaving GAP when the timer would next read PERIOD puts the IDLE cycle
   // exactly PERIOD cycles after FIRE, so start-to-start is PERIOD+1.
   always_comb begin
      next = state;
      case (state)
         IDLE: next = (enable && !stop) ? FIRE : IDLE;
         FIRE: next = WAIT;
         WAIT: next = (stop || tick == CNT_W'(TIMEOUT)) ? GAP : WAIT;
         GAP:  next = (timer == PW'(PERIOD - 1)) ? IDLE : GAP;
         default: next = IDLE;
      endcase
   end
   always_comb begin
      start = (state == FIRE);
      busy  = (state == FIRE) || (state == WAIT);
   end
   always_ff @(posedge clk_fast or negedge rstn)
      if (!rstn) begin
         tick        <= '0;
         timer       <= '0;
         sum         <= '0;
         cnt         <= '0;
         phase_diff  <= '0;
         phase_avg   <= '0;
         avg_valid   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         avg_valid <= 1'b0;
         // Loaded with 1 so the first WAIT cycle already reads tick 1.
         tick  <= (state == FIRE) ? CNT_W'(1) : tick + 1'b1;
         timer <= (state == FIRE) ? PW'(1) : timer + 1'b1;
         if (hit) begin
            phase_diff <= tick;
            if (cnt_n[AVG_LOG2]) begin
               phase_avg <= sum_n[SUM_W-1:AVG_LOG2];
               avg_valid <= 1'b1;
               sum       <= '0;
               cnt       <= '0;
            end else begin
               sum <= sum_n;
               cnt <= cnt_n;
            end
         end
         if (state == IDLE && !enable) begin
            sum <= '0;
            cnt <= '0;
         end
         if (tout)           timeout_err <= 1'b1;
         else if (clear_err) timeout_err <= 1'b0;
      end
endmodule

// File: tb/tb_phase_probe_tx.sv
// tb_phase_probe_tx: directed bench for phase_probe_tx (PERIOD=64, TIMEOUT=20,
// AVG_LOG2=2) with hand-computed expected phases, averages and spacing.
module tb_phase_probe_tx;
   logic        clk_fast = 1'b0;
   logic        rstn, enable, stop, clear_err;
   logic        start, busy, avg_valid, timeout_err;
   logic [15:0] phase_diff, phase_avg;
   int          tests = 0, fails = 0, cyc = 0, prev = -1;

   phase_probe_tx #(.CNT_W(16), .PERIOD(64), .TIMEOUT(20), .AVG_LOG2(2)) dut (
      .clk_fast(clk_fast), .rstn(rstn), .enable(enable), .stop(stop),
      .clear_err(clear_err), .start(start), .busy(busy),
      .phase_diff(phase_diff), .phase_avg(phase_avg),
      .avg_valid(avg_valid), .timeout_err(timeout_err)
   );

   always #5 clk_fast = ~clk_fast;
   always @(posedge clk_fast) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step;
      @(posedge clk_fast);
      #1;
   endtask

   task automatic wait_start(input int bound);
      int n = 0;
      while (!start && n < bound) begin
         step;
         n++;
      end
      chk("start_seen", int'(start), 1);
      chk("busy_fire", int'(busy), 1);
      if (prev >= 0) chk("spacing", cyc - prev, 65);
      prev = cyc;
   endtask

   // d = echo delay in ticks (0 = no echo); called in the FIRE cycle.
   task automatic run_probe(input int d, input int pd, input bit v, input int avg, input bit err);
      step;
      chk("start_width", int'(start), 0);
      chk("busy_wait", int'(busy), 1);
      if (d > 0) begin
         repeat (d - 1) step;
         stop = 1'b1;
         step;
         stop = 1'b0;
      end else begin
         repeat (20) step;
      end
      chk("phase_diff", int'(phase_diff), pd);
      chk("avg_valid", int'(avg_valid), int'(v));
      if (v) chk("phase_avg", int'(phase_avg), avg);
      chk("timeout_err", int'(timeout_err), int'(err));
      step;
      chk("avg_pulse", int'(avg_valid), 0);
      chk("busy_gap", int'(busy), 0);
   endtask

   task automatic probe(input int d, input int pd, input bit v, input int avg, input bit err);
      wait_start(200);
      run_probe(d, pd, v, avg, err);
   endtask

   task automatic clear_error;
      clear_err = 1'b1;
      step;
      clear_err = 1'b0;
      chk("clear_err", int'(timeout_err), 0);
   endtask

   initial begin
      rstn = 1'b1; enable = 1'b0; stop = 1'b0; clear_err = 1'b0;
      #2 rstn = 1'b0;
      step;
      step;
      chk("rst_start", int'(start), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pd", int'(phase_diff), 0);
      chk("rst_avg", int'(phase_avg), 0);
      chk("rst_valid", int'(avg_valid), 0);
      chk("rst_err", int'(timeout_err), 0);
      rstn = 1'b1; enable = 1'b1;
      // 1: constant 5-tick loopback
      probe(5, 5, 0, 0, 0);
      probe(5, 5, 0, 0, 0);
      probe(5, 5, 0, 0, 0);
      probe(5, 5, 1, 5, 0);
      // 2: varying delays
      probe(3, 3, 0, 0, 0);
      probe(4, 4, 0, 0, 0);
      probe(5, 5, 0, 0, 0);
      probe(6, 6, 1, 4, 0);
      probe(7, 7, 0, 0, 0);
      probe(7, 7, 0, 0, 0);
      probe(7, 7, 0, 0, 0);
      probe(8, 8, 1, 7, 0);
      // 3: missing echo is not counted; (9+9+10+11)>>2 = 9
      probe(9, 9, 0, 0, 0);
      probe(0, 9, 0, 0, 1);
      probe(9, 9, 0, 0, 1);
      probe(10, 10, 0, 0, 1);
      probe(11, 11, 1, 9, 1);
      clear_error;
      // 4: echo on the timeout tick is good, one later is a miss
      probe(20, 20, 0, 0, 0);
      probe(21, 20, 0, 0, 1);
      clear_error;
      // 5: stop held high across period expiry withholds start
      while (cyc < prev + 60) step;
      stop = 1'b1;
      repeat (14) begin
         step;
         chk("start_held", int'(start), 0);
      end
      stop = 1'b0;
      step;
      chk("start_after_quiet", int'(start), 1);
      prev = cyc;
      run_probe(0, 20, 0, 0, 1);
      // 6: async reset mid-WAIT clears outputs and the partial average
      wait_start(200);
      step;
      step;
      chk("busy_pre_rst", int'(busy), 1);
      #3 rstn = 1'b0;
      #1;
      chk("arst_start", int'(start), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_pd", int'(phase_diff), 0);
      chk("arst_avg", int'(phase_avg), 0);
      chk("arst_err", int'(timeout_err), 0);
      step;
      rstn = 1'b1;
      prev = -1;
      wait_start(2);
      run_probe(6, 6, 0, 0, 0);
      probe(6, 6, 0, 0, 0);
      probe(6, 6, 0, 0, 0);
      probe(6, 6, 1, 6, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
